// File: rtl/pipe_sequencer.sv
// Camera pipeline sequencer: power-up delay, camera config with timeout/retry,
// then frame-synchronous Gaussian filter mode switching with a pipeline flush.
module pipe_sequencer #(
    parameter int unsigned POWERUP_WAIT = 1250000,
    parameter int unsigned CFG_TIMEOUT  = 12500000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        i_sysclk,
    input  logic        db_rstn,
    input  logic        i_sof,
    input  logic        i_cfg_done,
    input  logic        i_sw_gaussian,
    output logic        o_cfg_start,
    output logic        o_gaussian_enable,
    output logic        o_pipe_flush,
    output logic [2:0]  o_state,
    output logic [15:0] o_frame_count,
    output logic        o_cfg_error
);

    localparam int unsigned MAX_AB  = (POWERUP_WAIT > CFG_TIMEOUT) ? POWERUP_WAIT : CFG_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > FLUSH_CYCLES) ? MAX_AB : FLUSH_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam int          RTY_W   = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLS_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PWRUP    = 3'd1,
        CFG_GO   = 3'd2,
        CFG_WAIT = 3'd3,
        SYNC     = 3'd4,
        RUN      = 3'd5,
        FLUSH    = 3'd6,
        ERROR    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             gen_q, gen_d;
    logic             pend_q, pend_d;
    logic [15:0]      fcnt_q, fcnt_d;

    logic             sw_meta_q, sw_sync_q, sw_acc_q;
    logic [3:0]       sw_hist_q;

    // Two-flop synchronizer, then the value is only accepted after four equal samples.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
            sw_hist_q <= '0;
            sw_acc_q  <= 1'b0;
        end else begin
            sw_meta_q <= i_sw_gaussian;
            sw_sync_q <= sw_meta_q;
            sw_hist_q <= {sw_hist_q[2:0], sw_sync_q};
            if (&sw_hist_q) begin
                sw_acc_q <= 1'b1;
            end else if (~|sw_hist_q) begin
                sw_acc_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            gen_q   <= 1'b0;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            gen_q   <= gen_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        gen_d   = gen_q;
        pend_d  = 1'b0;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                state_d = PWRUP;
                cnt_d   = '0;
            end
            PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = CFG_GO;
                    cnt_d   = '0;
                end
            end
            CFG_GO: begin
                state_d = CFG_WAIT;
                cnt_d   = '0;
            end
            CFG_WAIT: begin
                if (i_cfg_done) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_q < RTY_MAX) ? CFG_GO : ERROR;
                    cnt_d   = '0;
                end
            end
            SYNC: begin
                cnt_d = '0;
                if (i_sof) begin
                    gen_d   = sw_acc_q;
                    fcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d  = '0;
                pend_d = (sw_acc_q != gen_q);
                if (i_sof) begin
                    fcnt_d = fcnt_q + 16'd1;
                    // Only a pending flag already registered before this sof triggers a switch.
                    if (pend_q) begin
                        state_d = FLUSH;
                        gen_d   = ~gen_q;
                        pend_d  = 1'b0;
                    end
                end
            end
            FLUSH: begin
                pend_d = (sw_acc_q != gen_q);
                if (i_sof) begin
                    fcnt_d = fcnt_q + 16'd1;
                end
                if (cnt_q == FLS_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            ERROR: begin
                cnt_d  = '0;
                gen_d  = 1'b0;
                fcnt_d = '0;
            end
        endcase
    end

    assign o_state           = state_q;
    assign o_cfg_start       = (state_q == CFG_GO);
    assign o_pipe_flush      = (state_q == FLUSH);
    assign o_cfg_error       = (state_q == ERROR);
    assign o_gaussian_enable = gen_q;
    assign o_frame_count     = fcnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: config bring-up, retry exhaustion, mode
// switching table, frame counter wrap and asynchronous reset during flush.
module tb_pipe_sequencer;

    logic        i_sysclk = 1'b0;
    logic        db_rstn  = 1'b0;
    logic        i_sof = 1'b0, i_cfg_done = 1'b0, i_sw_gaussian = 1'b0;
    logic        o_cfg_start, o_gaussian_enable, o_pipe_flush, o_cfg_error;
    logic [2:0]  o_state;
    logic [15:0] o_frame_count;

    int checks = 0;
    int errors = 0;

    pipe_sequencer #(
        .POWERUP_WAIT(16), .CFG_TIMEOUT(100), .MAX_RETRIES(2), .FLUSH_CYCLES(4)
    ) dut (
        .i_sysclk(i_sysclk), .db_rstn(db_rstn), .i_sof(i_sof), .i_cfg_done(i_cfg_done),
        .i_sw_gaussian(i_sw_gaussian), .o_cfg_start(o_cfg_start),
        .o_gaussian_enable(o_gaussian_enable), .o_pipe_flush(o_pipe_flush),
        .o_state(o_state), .o_frame_count(o_frame_count), .o_cfg_error(o_cfg_error)
    );

    always #4 i_sysclk = ~i_sysclk;

    typedef struct {
        logic        sw;
        logic        sof;
        int          cyc;
        logic [2:0]  st;
        logic        gen;
        logic        fl;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " state"}, 32'(o_state), 32'd0);
        chk({tag, " cfg_start"}, 32'(o_cfg_start), 32'd0);
        chk({tag, " gauss_en"}, 32'(o_gaussian_enable), 32'd0);
        chk({tag, " flush"}, 32'(o_pipe_flush), 32'd0);
        chk({tag, " frame_cnt"}, 32'(o_frame_count), 32'd0);
        chk({tag, " cfg_error"}, 32'(o_cfg_error), 32'd0);
    endtask

    initial begin
        int pulses;
        int first_edge;
        int pulse_edge[$];

        //         sw    sof   cyc st    gen   fl    frames
        tbl[0]  = '{1'b0, 1'b1, 1,  3'd5, 1'b0, 1'b0, 16'd1};
        tbl[1]  = '{1'b1, 1'b0, 12, 3'd5, 1'b0, 1'b0, 16'd1};
        tbl[2]  = '{1'b1, 1'b1, 1,  3'd6, 1'b1, 1'b1, 16'd2};
        tbl[3]  = '{1'b1, 1'b0, 2,  3'd6, 1'b1, 1'b1, 16'd2};
        tbl[4]  = '{1'b1, 1'b1, 1,  3'd6, 1'b1, 1'b1, 16'd3};
        tbl[5]  = '{1'b1, 1'b0, 1,  3'd5, 1'b1, 1'b0, 16'd3};
        tbl[6]  = '{1'b0, 1'b0, 2,  3'd5, 1'b1, 1'b0, 16'd3};
        tbl[7]  = '{1'b1, 1'b0, 12, 3'd5, 1'b1, 1'b0, 16'd3};
        tbl[8]  = '{1'b1, 1'b1, 1,  3'd5, 1'b1, 1'b0, 16'd4};
        tbl[9]  = '{1'b0, 1'b0, 12, 3'd5, 1'b1, 1'b0, 16'd4};
        tbl[10] = '{1'b1, 1'b0, 12, 3'd5, 1'b1, 1'b0, 16'd4};
        tbl[11] = '{1'b1, 1'b1, 1,  3'd5, 1'b1, 1'b0, 16'd5};
        tbl[12] = '{1'b0, 1'b0, 7,  3'd5, 1'b1, 1'b0, 16'd5};
        tbl[13] = '{1'b0, 1'b1, 1,  3'd5, 1'b1, 1'b0, 16'd6};
        tbl[14] = '{1'b0, 1'b0, 2,  3'd5, 1'b1, 1'b0, 16'd6};
        tbl[15] = '{1'b0, 1'b1, 1,  3'd6, 1'b0, 1'b1, 16'd7};
        tbl[16] = '{1'b1, 1'b0, 3,  3'd6, 1'b0, 1'b1, 16'd7};
        tbl[17] = '{1'b1, 1'b0, 1,  3'd5, 1'b0, 1'b0, 16'd7};
        tbl[18] = '{1'b1, 1'b0, 10, 3'd5, 1'b0, 1'b0, 16'd7};
        tbl[19] = '{1'b1, 1'b1, 1,  3'd6, 1'b1, 1'b1, 16'd8};
        tbl[20] = '{1'b1, 1'b0, 4,  3'd5, 1'b1, 1'b0, 16'd8};

        // Bring-up: one config pulse, done arrives 10 cycles later.
        repeat (3) @(negedge i_sysclk);
        chk_reset_outputs("in_reset");
        db_rstn = 1'b1;
        pulses = 0;
        first_edge = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge i_sysclk);
            if (o_cfg_start) begin
                pulses++;
                if (first_edge < 0) first_edge = k;
            end
            if (k == 16) chk("pwrup_last_cycle", 32'(o_state), 32'd1);
            if (k == 17) chk("cfg_go_state", 32'(o_state), 32'd2);
            if (k == 27) i_cfg_done = 1'b1;
            if (k == 28) chk("sync_after_done", 32'(o_state), 32'd4);
        end
        chk("cfg_start_pulses", 32'(pulses), 32'd1);
        chk("cfg_start_cycle18", 32'(first_edge + 1), 32'd18);
        $display("bringup: start pulses %0d at cycle %0d, state %0d", pulses, first_edge + 1, o_state);

        i_sof = 1'b1;
        @(negedge i_sysclk);
        i_sof = 1'b0;
        chk("run_after_sof", 32'(o_state), 32'd5);
        chk("run_frame_cnt0", 32'(o_frame_count), 32'd0);
        chk("run_gauss_en0", 32'(o_gaussian_enable), 32'd0);
        i_cfg_done = 1'b0;

        // Run-mode switching table.
        for (int v = 0; v < 21; v++) begin
            i_sw_gaussian = tbl[v].sw;
            i_sof = tbl[v].sof;
            @(negedge i_sysclk);
            i_sof = 1'b0;
            repeat (tbl[v].cyc - 1) @(negedge i_sysclk);
            chk($sformatf("vec%0d state", v), 32'(o_state), 32'(tbl[v].st));
            chk($sformatf("vec%0d gauss_en", v), 32'(o_gaussian_enable), 32'(tbl[v].gen));
            chk($sformatf("vec%0d flush", v), 32'(o_pipe_flush), 32'(tbl[v].fl));
            chk($sformatf("vec%0d frame_cnt", v), 32'(o_frame_count), 32'(tbl[v].fc));
            $display("vec %0d: sw=%0b sof=%0b state=%0d en=%0b flush=%0b frames=%0d",
                     v, tbl[v].sw, tbl[v].sof, o_state, o_gaussian_enable, o_pipe_flush, o_frame_count);
        end

        // Frame counter wrap: 8 + 65527 = 0xFFFF, then one more sof.
        i_sof = 1'b1;
        repeat (65527) @(negedge i_sysclk);
        chk("frame_cnt_ffff", 32'(o_frame_count), 32'h0000_FFFF);
        @(negedge i_sysclk);
        i_sof = 1'b0;
        chk("frame_cnt_wrap", 32'(o_frame_count), 32'd0);
        chk("wrap_still_run", 32'(o_state), 32'd5);
        $display("wrap: frames=%0h state=%0d", o_frame_count, o_state);

        // Asynchronous reset in the middle of a flush.
        i_sw_gaussian = 1'b0;
        repeat (12) @(negedge i_sysclk);
        i_sof = 1'b1;
        @(negedge i_sysclk);
        i_sof = 1'b0;
        @(negedge i_sysclk);
        chk("mid_flush_flush", 32'(o_pipe_flush), 32'd1);
        db_rstn = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        $display("reset during flush: state=%0d flush=%0b", o_state, o_pipe_flush);

        // Config never completes: three starts 101 cycles apart, then ERROR.
        @(negedge i_sysclk);
        db_rstn = 1'b1;
        pulse_edge.delete();
        for (int k = 1; k <= 400; k++) begin
            @(negedge i_sysclk);
            i_sof = 1'b0;
            if (o_cfg_start) pulse_edge.push_back(k);
            if (k == 319) chk("last_wait_state", 32'(o_state), 32'd3);
            if (k == 320) chk("error_state", 32'(o_state), 32'd7);
            if (k % 7 == 3) i_sof = 1'b1;
        end
        i_sof = 1'b0;
        chk("retry_pulses", 32'(pulse_edge.size()), 32'd3);
        if (pulse_edge.size() == 3) begin
            chk("retry_gap1", 32'(pulse_edge[1] - pulse_edge[0]), 32'd101);
            chk("retry_gap2", 32'(pulse_edge[2] - pulse_edge[1]), 32'd101);
        end
        chk("err_state", 32'(o_state), 32'd7);
        chk("err_flag", 32'(o_cfg_error), 32'd1);
        chk("err_gauss_en", 32'(o_gaussian_enable), 32'd0);
        chk("err_flush", 32'(o_pipe_flush), 32'd0);
        chk("err_frame_cnt", 32'(o_frame_count), 32'd0);
        chk("err_cfg_start", 32'(o_cfg_start), 32'd0);
        $display("retry: pulses=%0d state=%0d cfg_error=%0b", pulse_edge.size(), o_state, o_cfg_error);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
